mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
- Iterative RV64M multiply/divide unit, parametrised on XLEN, with RV64 word-variant (W) support.
- Sits beside the ALU in the execute stage. The control unit holds the pipeline while o_busy is high and captures o_result on o_done.
- Radix-2 datapath: one bit per cycle. Divide-by-zero and signed-overflow cases take a fast path.

Parameters:
- XLEN, 64, operand/result width; must be 32 or 64. W variants are legal only when XLEN=64.

Ports:
- i_clk  input  1  clock, rising edge.
- i_arstn  input  1  reset, asynchronous, active-low.
- i_start  input  1  request; sampled only in IDLE or DONE.
- i_func_3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- i_word  input  1  W variant: operate on bits [31:0], sign-extend the result.
- i_rs1  input  XLEN  dividend / multiplicand.
- i_rs2  input  XLEN  divisor / multiplier.
- i_flush  input  1  abort the current operation.
- o_busy  output  XLEN-independent 1  high in ITER and FIX states.
- o_done  output  1  one-cycle pulse; o_result is valid.
- o_result  output  XLEN  result; held until the next o_done.

Behaviour:
- Reset (i_arstn=0, asynchronous):
  - state=IDLE; o_busy=0, o_done=0, o_result=0.
  - All internal registers are cleared.
  - Reset mid-operation discards the operation; no o_done follows.
- States:
  - IDLE: i_start=1 latches func/word/operands.
    - Fast-path case -> FIX.
    - Otherwise -> ITER; iteration counter = N-1, where N=32 if i_word else XLEN.
  - ITER: one shift-add (MUL*) or restoring shift-subtract (DIV*/REM*) step per cycle on operand magnitudes. Counter 0 -> FIX.
  - FIX:
    - Apply sign correction: negate the product if the signs differ; negate the quotient if the signs differ; the remainder takes the dividend's sign.
    - Select the half: low XLEN for MUL, high XLEN for MULH*.
    - For W, take bits [31:0] and sign-extend bit 31.
    - Register o_result -> DONE.
  - DONE: o_done=1 for exactly one cycle.
    - i_start=1 here is accepted exactly as in IDLE (back-to-back).
    - Otherwise -> IDLE.
- Operand signedness: MULH and DIV/REM treat both operands as signed; MULHSU treats rs1 signed and rs2 unsigned; MULHU/DIVU/REMU treat both as unsigned; MUL is sign-agnostic.
- Latency, counted from the edge sampling i_start to the cycle with o_done=1:
  - Normal path: N+2 cycles (66 for XLEN=64, 34 for W).
  - Fast path: 2 cycles.
- Fast path:
  - Divisor (masked to 32 bits if W) == 0: quotient = all ones; remainder = dividend (sign-extended if W).
  - Signed overflow (most-negative / -1, DIV/REM only): quotient = dividend; remainder = 0.
- i_word with func_3 001/010/011 is illegal; the unit executes the non-W form.
- i_start while in ITER/FIX is ignored; the operation in flight is unaffected.
- i_flush:
  - In ITER/FIX: state -> IDLE on the next edge; no o_done; o_result unchanged.
  - Takes priority over counter expiry in the same cycle.
  - In IDLE/DONE it has no effect.
  - i_flush together with i_start in IDLE: the flush wins and the start is dropped.
- The product accumulator is 2*XLEN bits wide; the remainder register is XLEN+1 bits wide (for the subtract sign).

Decomposition:
- Package mul_div_pkg:
  - func_3 encoding enum (MUL..REMU).
  - State enum (IDLE, ITER, FIX, DONE).
  - Constants W_LEN=32 and MUL_DIV_MIN_XLEN=32.
- Sub-module mul_div_operand_prep (combinational):
  - W truncation and sign-extension of operands.
  - Magnitude/sign extraction per func_3.
  - Divide-by-zero and overflow detection.
- The iterative datapath and FSM stay in mul_div_unit.

Test Plan (XLEN=64):
- MUL rs1=7, rs2=0xFFFF_FFFF_FFFF_FFFD (-3) -> o_result=0xFFFF_FFFF_FFFF_FFEB; o_done exactly 66 cycles after start; o_busy high 65 cycles.
- MULH rs1=0x8000_0000_0000_0000, rs2=2 -> 0xFFFF_FFFF_FFFF_FFFF. The same operands with MULHU -> 0x1; with MULHSU -> 0xFFFF_FFFF_FFFF_FFFF.
- Divide by zero:
  - DIVU rs1=100, rs2=0 -> 0xFFFF_FFFF_FFFF_FFFF.
  - REM rs1=100, rs2=0 -> 100.
  - DIV 0x8000_0000_0000_0000 / 0xFFFF_FFFF_FFFF_FFFF -> 0x8000_0000_0000_0000; REM of the same operands -> 0.
  - Each completes 2 cycles after start.
- DIVW rs1=0x0000_0001_FFFF_FFF9, rs2=2 -> 0xFFFF_FFFF_FFFF_FFFD; REMW -> 0xFFFF_FFFF_FFFF_FFFF; MULW rs1=0x0001_0000_0000_0002, rs2=0x4000_0000 -> 0xFFFF_FFFF_8000_0000. o_done at 34 cycles for each.
- Control and reset:
  - i_start pulses during ITER -> ignored; result matches a single operation.
  - Back-to-back start in the DONE cycle -> second o_done 66 cycles later.
  - i_flush at cycle 10 -> IDLE, no o_done; o_result keeps its previous value.
  - i_arstn pulled low at cycle 20 -> o_busy=0, o_done=0, o_result=0 immediately.

Source files
------------

// File: rtl/mul_div_pkg.sv
// mul_div_pkg: shared encodings and constants for the iterative multiply/divide unit
package mul_div_pkg;
  typedef enum logic [2:0] {MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU} func_e;
  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_e;
  localparam int W_LEN = 32;
  localparam int MUL_DIV_MIN_XLEN = 32;
endpackage

// File: rtl/mul_div_if.sv
// mul_div_if: request/response bundle between the control unit and the multiply/divide unit
interface mul_div_if #(parameter int XLEN = 64);
  logic            i_start;
  logic [2:0]      i_func_3;
  logic            i_word;
  logic [XLEN-1:0] i_rs1;
  logic [XLEN-1:0] i_rs2;
  logic            i_flush;
  logic            o_busy;
  logic            o_done;
  logic [XLEN-1:0] o_result;
  modport master (output i_start, i_func_3, i_word, i_rs1, i_rs2, i_flush, input o_busy, o_done, o_result);
  modport slave (input i_start, i_func_3, i_word, i_rs1, i_rs2, i_flush, output o_busy, o_done, o_result);
endinterface

// File: rtl/mul_div_operand_prep.sv
// mul_div_operand_prep: word truncation, operand magnitudes/signs and fast-path detection
module mul_div_operand_prep import mul_div_pkg::*; #(
  parameter int XLEN = 64
) (
  input  func_e           func_i,
  input  logic            word_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic            word_o,
  output logic [XLEN-1:0] a_mag_o,
  output logic [XLEN-1:0] b_mag_o,
  output logic            a_neg_o,
  output logic            b_neg_o,
  output logic            fast_o,
  output logic [XLEN-1:0] fast_val_o
);
  logic a_sgn, b_sgn, dz, ovf;
  logic [XLEN-1:0] a_ext, b_ext;
  // MULH* have no word form, so the word flag is dropped for them
  always_comb begin
    word_o = word_i && !(func_i inside {MULH, MULHSU, MULHU}) && XLEN > MUL_DIV_MIN_XLEN;
    a_sgn = func_i inside {MULH, MULHSU, DIV, REM};
    b_sgn = func_i inside {MULH, DIV, REM};
    a_ext = word_o ? (a_sgn ? XLEN'($signed(rs1_i[W_LEN-1:0])) : XLEN'(rs1_i[W_LEN-1:0])) : rs1_i;
    b_ext = word_o ? (b_sgn ? XLEN'($signed(rs2_i[W_LEN-1:0])) : XLEN'(rs2_i[W_LEN-1:0])) : rs2_i;
    a_neg_o = a_sgn && a_ext[XLEN-1];
    b_neg_o = b_sgn && b_ext[XLEN-1];
    a_mag_o = a_neg_o ? -a_ext : a_ext;
    b_mag_o = b_neg_o ? -b_ext : b_ext;
    dz = func_i[2] && b_ext == '0;
    ovf = func_i inside {DIV, REM} && &b_ext &&
          (word_o ? a_ext[W_LEN-1:0] == 32'h8000_0000 : a_ext == {1'b1, {(XLEN-1){1'b0}}});
    fast_o = dz || ovf;
    fast_val_o = dz ? (func_i[1] ? a_ext : '1) : (func_i[1] ? '0 : a_ext);
  end
endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: radix-2 iterative RV64M multiply/divide with word variants and fast paths
module mul_div_unit import mul_div_pkg::*; #(
  parameter int XLEN = 64
) (
  input logic     i_clk,
  input logic     i_arstn,
  mul_div_if.slave bus
);
  localparam int CW = $clog2(XLEN);
  state_e state_q, state_d;
  func_e func_q;
  logic word_q, a_neg_q, b_neg_q, fast_q, accept, ge;
  logic [CW-1:0] cnt_q;
  logic [XLEN-1:0] mcand_q, res_q, load_lo, mul_res, quo, remv, raw, res;
  logic [2*XLEN-1:0] acc_q, prod;
  logic [XLEN:0] rem_q, sum, rs, diff;
  logic p_word, p_a_neg, p_b_neg, p_fast;
  logic [XLEN-1:0] p_a_mag, p_b_mag, p_fast_val;
  mul_div_operand_prep #(.XLEN(XLEN)) u_prep (
    .func_i(func_e'(bus.i_func_3)),
    .word_i(bus.i_word),
    .rs1_i(bus.i_rs1),
    .rs2_i(bus.i_rs2),
    .word_o(p_word),
    .a_mag_o(p_a_mag),
    .b_mag_o(p_b_mag),
    .a_neg_o(p_a_neg),
    .b_neg_o(p_b_neg),
    .fast_o(p_fast),
    .fast_val_o(p_fast_val)
  );
  assign accept = bus.i_start && (state_q == DONE || (state_q == IDLE && !bus.i_flush));
  assign bus.o_busy = state_q == ITER || state_q == FIX;
  assign bus.o_done = state_q == DONE;
  assign bus.o_result = res_q;
  // iteration step, initial load value and final sign/half/word selection
  always_comb begin
    load_lo = p_fast ? p_fast_val : bus.i_func_3[2] ? (p_word ? p_a_mag << (XLEN - W_LEN) : p_a_mag) : p_b_mag;
    sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    rs = {rem_q[XLEN-1:0], acc_q[XLEN-1]};
    diff = rs - {1'b0, mcand_q};
    ge = !diff[XLEN];
    prod = (a_neg_q ^ b_neg_q) ? -acc_q : acc_q;
    mul_res = func_q == MUL ? (word_q ? XLEN'(prod[XLEN-W_LEN +: W_LEN]) : prod[XLEN-1:0]) : prod[2*XLEN-1:XLEN];
    quo = (a_neg_q ^ b_neg_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    remv = XLEN'(a_neg_q ? -rem_q : rem_q);
    raw = fast_q ? acc_q[XLEN-1:0] : func_q[2] ? (func_q[1] ? remv : quo) : mul_res;
    res = word_q ? XLEN'($signed(raw[W_LEN-1:0])) : raw;
  end
  // state register
  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) state_q <= IDLE;
    else state_q <= state_d;
  end
  // next state; flush beats both counter expiry and a start in IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: state_d = accept ? (p_fast ? FIX : ITER) : IDLE;
      ITER: state_d = bus.i_flush ? IDLE : (cnt_q == '0 ? FIX : ITER);
      FIX: state_d = bus.i_flush ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  // operand capture, shift-add / restoring shift-subtract, result register
  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      func_q <= MUL;
      word_q <= 1'b0;
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
      fast_q <= 1'b0;
      cnt_q <= '0;
      mcand_q <= '0;
      acc_q <= '0;
      rem_q <= '0;
      res_q <= '0;
    end else begin
      if (accept) begin
        func_q <= func_e'(bus.i_func_3);
        word_q <= p_word;
        a_neg_q <= p_a_neg;
        b_neg_q <= p_b_neg;
        fast_q <= p_fast;
        cnt_q <= p_word ? CW'(W_LEN - 1) : CW'(XLEN - 1);
        mcand_q <= bus.i_func_3[2] ? p_b_mag : p_a_mag;
        acc_q <= {{XLEN{1'b0}}, load_lo};
        rem_q <= '0;
      end else if (state_q == ITER) begin
        cnt_q <= cnt_q - CW'(1);
        acc_q <= func_q[2] ? {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], ge} : {sum, acc_q[XLEN-1:1]};
        rem_q <= func_q[2] ? (ge ? diff : rs) : rem_q;
      end
      if (state_q == FIX && !bus.i_flush) res_q <= res;
    end
  end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed vectors with a scoreboard queue checked by an independent monitor
module tb_mul_div_unit;
  import mul_div_pkg::*;
  typedef struct {
    string       name;
    logic [63:0] val;
    int          lat;
    int          t0;
  } exp_t;
  logic clk = 1'b0;
  logic arstn = 1'b0;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int busy_n;
  logic [63:0] last_exp = '0;
  exp_t sb[$];
  mul_div_if #(.XLEN(64)) bus();
  mul_div_unit #(.XLEN(64)) dut (.i_clk(clk), .i_arstn(arstn), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // monitor: every o_done pops one expectation and checks value and latency
  always @(negedge clk) begin
    if (arstn === 1'b1 && bus.o_done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done result=%h", bus.o_result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        if (bus.o_result !== e.val) begin
          failures++;
          $display("FAIL %s result got=%h exp=%h", e.name, bus.o_result, e.val);
        end
        checks++;
        if (cyc - e.t0 != e.lat) begin
          failures++;
          $display("FAIL %s latency got=%0d exp=%0d", e.name, cyc - e.t0, e.lat);
        end
      end
    end
  end
  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask
  task automatic issue(input logic [2:0] f, input logic w, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp, input int lat, input string nm, input bit push);
    bus.i_func_3 = f;
    bus.i_word = w;
    bus.i_rs1 = a;
    bus.i_rs2 = b;
    bus.i_start = 1'b1;
    if (push) sb.push_back('{name: nm, val: exp, lat: lat, t0: cyc});
    @(negedge clk);
    bus.i_start = 1'b0;
  endtask
  task automatic wait_done(input string nm, output int nb);
    bit seen = 1'b0;
    nb = 0;
    for (int i = 0; i < 200; i++) begin
      if (bus.o_done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      nb += int'(bus.o_busy === 1'b1);
      @(negedge clk);
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s timeout got=no_done exp=done", nm);
    end
  endtask
  task automatic run(input logic [2:0] f, input logic w, input logic [63:0] a, input logic [63:0] b,
                     input logic [63:0] exp, input int lat, input string nm, output int nb);
    issue(f, w, a, b, exp, lat, nm, 1'b1);
    wait_done(nm, nb);
    last_exp = exp;
    @(negedge clk);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.i_start = 1'b0;
    bus.i_func_3 = '0;
    bus.i_word = 1'b0;
    bus.i_rs1 = '0;
    bus.i_rs2 = '0;
    bus.i_flush = 1'b0;
    #12;
    check("rst_busy", 64'(bus.o_busy), 64'd0);
    check("rst_done", 64'(bus.o_done), 64'd0);
    check("rst_result", bus.o_result, 64'd0);
    @(negedge clk);
    arstn = 1'b1;
    @(negedge clk);
    run(MUL, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 66, "mul", busy_n);
    check("mul_busy_cycles", 64'(busy_n), 64'd65);
    run(MULH, 1'b0, 64'h8000_0000_0000_0000, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66, "mulh", busy_n);
    run(MULHU, 1'b0, 64'h8000_0000_0000_0000, 64'd2, 64'd1, 66, "mulhu", busy_n);
    run(MULHSU, 1'b0, 64'h8000_0000_0000_0000, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66, "mulhsu", busy_n);
    run(DIVU, 1'b0, 64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2, "divu_by0", busy_n);
    run(REM, 1'b0, 64'd100, 64'd0, 64'd100, 2, "rem_by0", busy_n);
    run(DIV, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 2, "div_ovf", busy_n);
    run(REM, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 2, "rem_ovf", busy_n);
    run(DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 66, "div_neg", busy_n);
    run(REM, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 66, "rem_neg", busy_n);
    run(DIV, 1'b1, 64'h0000_0001_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 34, "divw", busy_n);
    run(REM, 1'b1, 64'h0000_0001_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 34, "remw", busy_n);
    run(MUL, 1'b1, 64'h0001_0000_0000_0002, 64'h4000_0000, 64'hFFFF_FFFF_8000_0000, 34, "mulw", busy_n);
    run(MULHU, 1'b1, 64'h8000_0000_0000_0000, 64'd2, 64'd1, 66, "mulhu_word_ignored", busy_n);
    // start pulse while iterating must not disturb the operation in flight
    issue(DIVU, 1'b0, 64'd1000, 64'd7, 64'd142, 66, "start_in_iter", 1'b1);
    repeat (5) @(negedge clk);
    bus.i_func_3 = MUL;
    bus.i_rs1 = 64'd3;
    bus.i_rs2 = 64'd5;
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    wait_done("start_in_iter", busy_n);
    @(negedge clk);
    // back-to-back: second start issued in the DONE cycle
    issue(MUL, 1'b0, 64'd6, 64'd7, 64'd42, 66, "b2b_first", 1'b1);
    wait_done("b2b_first", busy_n);
    issue(REMU, 1'b0, 64'd100, 64'd7, 64'd2, 66, "b2b_second", 1'b1);
    wait_done("b2b_second", busy_n);
    last_exp = 64'd2;
    @(negedge clk);
    // flush in ITER: back to IDLE, no done, result kept
    issue(MUL, 1'b0, 64'd9, 64'd9, 64'd81, 66, "flushed", 1'b0);
    repeat (9) @(negedge clk);
    bus.i_flush = 1'b1;
    @(negedge clk);
    bus.i_flush = 1'b0;
    check("flush_busy", 64'(bus.o_busy), 64'd0);
    check("flush_result", bus.o_result, last_exp);
    repeat (80) @(negedge clk);
    check("flush_result_held", bus.o_result, last_exp);
    // flush together with start in IDLE drops the start
    bus.i_flush = 1'b1;
    issue(DIVU, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2, "idle_flush_start", 1'b0);
    bus.i_flush = 1'b0;
    check("idle_flush_busy", 64'(bus.o_busy), 64'd0);
    repeat (5) @(negedge clk);
    // asynchronous reset mid-operation
    issue(MUL, 1'b0, 64'd11, 64'd13, 64'd143, 66, "reset_mid", 1'b1);
    repeat (19) @(negedge clk);
    #2 arstn = 1'b0;
    #1;
    check("arst_busy", 64'(bus.o_busy), 64'd0);
    check("arst_done", 64'(bus.o_done), 64'd0);
    check("arst_result", bus.o_result, 64'd0);
    sb.delete();
    @(negedge clk);
    arstn = 1'b1;
    repeat (80) @(negedge clk);
    check("arst_no_done_result", bus.o_result, 64'd0);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
